cmem_arb: RTL and testbench

CMEM_ARB -- requirements
Module: cmem_arb

---
 rtl/cmem_arb.sv | 146 ++++++++++++++
 tb/tb_cmem_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_arb.sv
// cmem_arb: round-robin arbiter in front of the shared layer memory.
// Three requesters (0 conv, 1 pool, 2 flatten) compete for a single-ported
// memory. The grant is combinational; the memory command is registered one
// cycle after the grant, and read data comes back to the owner two cycles
// after the grant.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   req, we, lock    per-requester request, write(1)/read(0), keep-grant
//   sel, addr, wdata per-requester bank select / address / write data, packed
//   gnt              one-hot combinational grant
//   rvalid, rdata    one-hot read-valid to the read's owner, shared read data
//   err              one-cycle pulse for a grant with an illegal bank select
//   cwr, crd, csel   memory write strobe, read strobe, bank select
//   caddr_wr/rd      memory write / read address
//   cdata_wr         memory write data
//   cdata_rd         memory read data, sampled at the end of a crd cycle
module cmem_arb #(
  parameter int AW = 12,
  parameter int DW = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [8:0]      sel,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      err,
  output logic            cwr,
  output logic            crd,
  output logic [2:0]      csel,
  output logic [AW-1:0]   caddr_wr,
  output logic [AW-1:0]   caddr_rd,
  output logic [DW-1:0]   cdata_wr,
  input  logic [DW-1:0]   cdata_rd
);

  logic [1:0]    last_q;     // last granted requester
  logic          lock_q;     // last_q asked to keep the grant
  logic [2:0]    rd_pend_q;  // owner of the read currently on the memory port
  logic [1:0]    gidx;
  logic [1:0]    cand;
  logic          any_gnt;
  logic          g_legal;
  logic [2:0]    g_sel;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // A held lock wins only while its owner still requests; otherwise the
  // search starts just after the last winner and wraps 2 -> 0.
  always_comb begin
    gnt     = '0;
    gidx    = 2'd0;
    any_gnt = 1'b0;
    cand    = rr_next(last_q);
    if (lock_q && req[last_q]) begin
      any_gnt = 1'b1;
      gidx    = last_q;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!any_gnt && req[cand]) begin
          any_gnt = 1'b1;
          gidx    = cand;
        end
        cand = rr_next(cand);
      end
    end
    if (any_gnt) gnt[gidx] = 1'b1;
  end

  always_comb begin
    case (gidx)
      2'd1: begin
        g_sel   = sel[5:3];
        g_addr  = addr[2*AW-1:AW];
        g_wdata = wdata[2*DW-1:DW];
      end
      2'd2: begin
        g_sel   = sel[8:6];
        g_addr  = addr[3*AW-1:2*AW];
        g_wdata = wdata[3*DW-1:2*DW];
      end
      default: begin
        g_sel   = sel[2:0];
        g_addr  = addr[AW-1:0];
        g_wdata = wdata[DW-1:0];
      end
    endcase
  end

  // Banks 1..5 exist; 0, 6 and 7 are consumed as errors without an access.
  assign g_legal = any_gnt && (g_sel != 3'd0) && (g_sel <= 3'd5);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= 2'd2;
      lock_q    <= 1'b0;
      rd_pend_q <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      err       <= '0;
      cwr       <= 1'b0;
      crd       <= 1'b0;
      csel      <= '0;
      caddr_wr  <= '0;
      caddr_rd  <= '0;
      cdata_wr  <= '0;
    end else begin
      cwr <= 1'b0;
      crd <= 1'b0;
      err <= '0;
      if (any_gnt) begin
        last_q <= gidx;
        lock_q <= lock[gidx];
      end else begin
        lock_q <= 1'b0;
      end
      if (any_gnt && !g_legal) err <= gnt;
      if (g_legal) begin
        csel <= g_sel;
        if (we[gidx]) begin
          cwr      <= 1'b1;
          caddr_wr <= g_addr;
          cdata_wr <= g_wdata;
        end else begin
          crd      <= 1'b1;
          caddr_rd <= g_addr;
        end
      end
      rd_pend_q <= (g_legal && !we[gidx]) ? gnt : 3'b000;
      // Memory answers at the end of the crd cycle; hand it to the owner.
      rvalid <= rd_pend_q;
      if (|rd_pend_q) rdata <= cdata_rd;
    end
  end

endmodule

// File: tb/tb_cmem_arb.sv
module tb_cmem_arb;
  localparam int AW = 12;
  localparam int DW = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req = '0, we = '0, lock = '0;
  logic [8:0]      sel = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, rvalid, err, csel;
  logic [DW-1:0]   rdata, cdata_wr, cdata_rd;
  logic            cwr, crd;
  logic [AW-1:0]   caddr_wr, caddr_rd;

  cmem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .sel(sel),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr),
    .caddr_rd(caddr_rd), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten locations return a pattern derived from the address.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {8'h5A, a};
  endfunction

  logic [DW-1:0] mem [4096];
  logic [4095:0] wvld = '0;
  always @(posedge clk) begin
    if (cwr) begin
      mem[caddr_wr]  <= cdata_wr;
      wvld[caddr_wr] <= 1'b1;
    end
  end
  assign cdata_rd = wvld[caddr_rd] ? mem[caddr_rd] : init_val(caddr_rd);

  // Read scoreboard: expected rvalid/rdata pushed when a read is granted.
  typedef struct {
    int            due;
    logic [2:0]    owner;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      n_chk++;
      if (rvalid !== sb[0].owner || rdata !== sb[0].data) begin
        n_fail++;
        $display("FAIL rd_sb cyc=%0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, sb[0].owner, sb[0].data);
      end
      void'(sb.pop_front());
    end else begin
      n_chk++;
      if (rvalid !== 3'b000) begin
        n_fail++;
        $display("FAIL rvalid_idle cyc=%0d: got %b expected 000", cyc, rvalid);
      end
    end
  end

  task automatic clear_rq();
    req = '0; we = '0; lock = '0; sel = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_rq(input int i, input logic w, input logic l, input logic [2:0] s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    lock[i] = l;
    sel[3*i +: 3] = s;
    addr[AW*i +: AW] = a;
    wdata[DW*i +: DW] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_rq();
    for (int i = 0; i < 3; i++) set_rq(i, 1'b0, 1'b1, 3'd1, AW'(i), '0);
    repeat (3) @(negedge clk);
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rst_gnt: got %b expected 001", gnt); end
    n_chk++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 000", rvalid); end
    n_chk++; if (rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
    n_chk++; if (err !== 3'b000) begin n_fail++; $display("FAIL rst_err: got %b expected 000", err); end
    n_chk++; if ({cwr, crd} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b expected 00", {cwr, crd}); end
    n_chk++; if (csel !== 3'd0) begin n_fail++; $display("FAIL rst_csel: got %0d expected 0", csel); end
    n_chk++; if ({caddr_wr, caddr_rd} !== '0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", {caddr_wr, caddr_rd}); end
    n_chk++; if (cdata_wr !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", cdata_wr); end
    @(negedge clk);
    clear_rq();
    reset = 1'b1;
  endtask

  task automatic test_rr_reads();
    logic [2:0]    exp_g [6];
    logic [AW-1:0] prev_a;
    logic [AW-1:0] a;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    prev_a = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_chk++; if ({cwr, crd} !== 2'b01) begin n_fail++; $display("FAIL rr_strobes k=%0d: got %b expected 01", k, {cwr, crd}); end
        n_chk++; if (caddr_rd !== prev_a) begin n_fail++; $display("FAIL rr_caddr k=%0d: got %h expected %h", k, caddr_rd, prev_a); end
        n_chk++; if (csel !== 3'd1) begin n_fail++; $display("FAIL rr_csel k=%0d: got %0d expected 1", k, csel); end
      end
      clear_rq();
      for (int i = 0; i < 3; i++) set_rq(i, 1'b0, 1'b0, 3'd1, AW'(12'h100 + 16 * i + k), '0);
      #1;
      n_chk++; if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL rr_gnt k=%0d: got %b expected %b", k, gnt, exp_g[k]); end
      a = AW'(12'h100 + 16 * (k % 3) + k);
      sb.push_back('{cyc + 2, exp_g[k], init_val(a)});
      prev_a = a;
    end
    @(negedge clk);
    n_chk++; if ({cwr, crd} !== 2'b01 || caddr_rd !== prev_a) begin n_fail++; $display("FAIL rr_last: got strobes %b addr %h expected 01 %h", {cwr, crd}, caddr_rd, prev_a); end
    clear_rq();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    clear_rq();
    set_rq(0, 1'b1, 1'b0, 3'd3, 12'h040, 20'hABCDE);
    #1;
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL wr_gnt: got %b expected 001", gnt); end
    @(negedge clk);
    n_chk++; if ({cwr, crd} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes: got %b expected 10", {cwr, crd}); end
    n_chk++; if (caddr_wr !== 12'h040 || cdata_wr !== 20'hABCDE) begin n_fail++; $display("FAIL wr_cmd: got %h/%h expected 040/abcde", caddr_wr, cdata_wr); end
    n_chk++; if (csel !== 3'd3) begin n_fail++; $display("FAIL wr_csel: got %0d expected 3", csel); end
    clear_rq();
    set_rq(1, 1'b0, 1'b0, 3'd3, 12'h040, '0);
    #1;
    n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt: got %b expected 010", gnt); end
    sb.push_back('{cyc + 2, 3'b010, 20'hABCDE});
    @(negedge clk);
    n_chk++; if ({cwr, crd} !== 2'b01 || caddr_rd !== 12'h040) begin n_fail++; $display("FAIL rd_cmd: got %b %h expected 01 040", {cwr, crd}, caddr_rd); end
    n_chk++; if (caddr_wr !== 12'h040 || cdata_wr !== 20'hABCDE) begin n_fail++; $display("FAIL rd_wr_hold: got %h/%h expected 040/abcde", caddr_wr, cdata_wr); end
    clear_rq();
    #1;
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 000", gnt); end
    @(negedge clk);
    n_chk++; if ({cwr, crd} !== 2'b00 || csel !== 3'd3 || caddr_rd !== 12'h040) begin n_fail++; $display("FAIL idle_hold: got %b csel %0d addr %h expected 00 3 040", {cwr, crd}, csel, caddr_rd); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    logic [2:0] exp_g [7];
    logic [2:0] rq [7];
    logic [2:0] lk [7];
    exp_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
    rq    = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b001, 3'b110};
    lk    = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      clear_rq();
      for (int i = 0; i < 3; i++)
        if (rq[k][i]) set_rq(i, 1'b1, lk[k][i], 3'd1, AW'(12'h300 + 16 * i + k), DW'(k));
      #1;
      n_chk++; if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL lock_gnt k=%0d: got %b expected %b", k, gnt, exp_g[k]); end
    end
    @(negedge clk);
    clear_rq();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    clear_rq();
    set_rq(2, 1'b0, 1'b0, 3'b110, 12'h050, '0);
    #1;
    n_chk++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL ill_gnt: got %b expected 100", gnt); end
    @(negedge clk);
    n_chk++; if (err !== 3'b100) begin n_fail++; $display("FAIL ill_err: got %b expected 100", err); end
    n_chk++; if ({cwr, crd} !== 2'b00 || csel !== 3'd1) begin n_fail++; $display("FAIL ill_noaccess: got %b csel %0d expected 00 1", {cwr, crd}, csel); end
    clear_rq();
    for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b0, 3'd2, AW'(12'h310 + i), DW'(i));
    #1;
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL ill_ptr: got %b expected 001", gnt); end
    @(negedge clk);
    n_chk++; if (err !== 3'b000 || cwr !== 1'b1) begin n_fail++; $display("FAIL ill_after: got err %b cwr %b expected 000 1", err, cwr); end
    clear_rq();
    set_rq(0, 1'b0, 1'b0, 3'd0, 12'h051, '0);
    #1;
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL sel0_gnt: got %b expected 001", gnt); end
    @(negedge clk);
    n_chk++; if (err !== 3'b001 || {cwr, crd} !== 2'b00) begin n_fail++; $display("FAIL sel0_err: got err %b strobes %b expected 001 00", err, {cwr, crd}); end
    clear_rq();
    set_rq(0, 1'b1, 1'b0, 3'd7, 12'h052, 20'h11111);
    #1;
    @(negedge clk);
    n_chk++; if (err !== 3'b001 || {cwr, crd} !== 2'b00 || csel !== 3'd2) begin n_fail++; $display("FAIL sel7_err: got err %b strobes %b csel %0d expected 001 00 2", err, {cwr, crd}, csel); end
    clear_rq();
    @(negedge clk);
    n_chk++; if (err !== 3'b000) begin n_fail++; $display("FAIL err_pulse: got %b expected 000", err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    clear_rq();
    set_rq(0, 1'b0, 1'b0, 3'd1, 12'h120, '0);
    #1;
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL mid_gnt: got %b expected 001", gnt); end
    @(negedge clk);
    n_chk++; if (crd !== 1'b1) begin n_fail++; $display("FAIL mid_crd: got %b expected 1", crd); end
    reset = 1'b0;
    clear_rq();
    #1;
    n_chk++; if ({cwr, crd, err, rvalid, csel} !== '0 || {caddr_rd, caddr_wr, cdata_wr, rdata} !== '0) begin
      n_fail++; $display("FAIL mid_rst_outs: got strobes %b err %b rvalid %b csel %0d addr %h", {cwr, crd}, err, rvalid, csel, caddr_rd);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_rq(i, 1'b0, 1'b0, 3'd1, AW'(12'h130 + i), '0);
    #1;
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL post_rst_gnt: got %b expected 001", gnt); end
    sb.push_back('{cyc + 2, 3'b001, init_val(12'h130)});
    @(negedge clk);
    n_chk++; if (crd !== 1'b1 || caddr_rd !== 12'h130) begin n_fail++; $display("FAIL post_rst_rd: got %b %h expected 1 130", crd, caddr_rd); end
    clear_rq();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_reads();
    test_write_read();
    test_lock();
    test_illegal();
    test_reset_midflight();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d reads outstanding expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
